flash_loader: RTL

- Debug-side writer and reader for the program FLASH that the MCU core fetches from.
- Consumes a byte stream from the host link (UART receiver, not part of this block) and decodes commands to write, read back and release the core.
- Drives the second FLASH port, which the core otherwise ties off, and holds the core halted while it owns the memory.

---
 rtl/flash_loader_pkg.sv | 22 ++
 rtl/loader_tx_hold.sv | 24 ++
 rtl/flash_loader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/flash_loader_pkg.sv
// Shared command/response bytes and FSM state encoding for the debug flash loader.
package flash_loader_pkg;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] UNK = 8'h3F;

  typedef enum logic [3:0] {
    IDLE, ADDR_H, ADDR_L, COUNT, DAT_H, DAT_L, WRITE, CHECK,
    RD_ISSUE, RD_WAIT, SEND_H, SEND_L, RESP
  } state_t;

  // States in which a host byte may be consumed.
  function automatic logic collects(state_t s);
    return s inside {IDLE, ADDR_H, ADDR_L, COUNT, DAT_H, DAT_L, CHECK};
  endfunction

endpackage

// File: rtl/loader_tx_hold.sv
// Single-entry response byte holding register with valid/ready handshake.
module loader_tx_hold (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_data;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/flash_loader.sv
// Host-command decoder that writes/reads the program flash and halts/releases the core.
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter int unsigned ADDR_W        = 14,
  parameter int unsigned RD_LAT        = 2,
  parameter bit          HALT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [15:0]       flash_d,
  output logic              flash_we,
  input  logic [15:0]       flash_q,
  output logic              cpu_halt,
  output logic              cpu_rst
);

  localparam int unsigned WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 2);

  state_t state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [7:0]  addr_hi, addr_hi_nxt, data_hi, data_hi_nxt, word_lo, word_lo_nxt;
  logic [7:0]  sum, sum_nxt, sum_in, resp, resp_nxt, tx_byte;
  logic [8:0]  cnt, cnt_nxt;
  logic [15:0] word, word_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic        is_wr, is_wr_nxt, halt, halt_nxt, crst, crst_nxt;
  logic        rx_fire, tx_load;

  assign rx_ready   = !rst && collects(state);
  assign rx_fire    = rx_valid && rx_ready;
  assign sum_in     = sum + rx_data;
  assign flash_we   = !rst && (state == WRITE);
  assign flash_addr = addr;
  assign flash_d    = word;
  assign cpu_halt   = halt;
  assign cpu_rst    = crst;

  loader_tx_hold u_tx_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .load_data (tx_byte),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      addr_hi  <= '0;
      data_hi  <= '0;
      word_lo  <= '0;
      sum      <= '0;
      resp     <= '0;
      cnt      <= '0;
      word     <= '0;
      wait_cnt <= '0;
      is_wr    <= 1'b0;
      halt     <= HALT_ON_RESET;
      crst     <= 1'b0;
    end else begin
      addr     <= addr_nxt;
      addr_hi  <= addr_hi_nxt;
      data_hi  <= data_hi_nxt;
      word_lo  <= word_lo_nxt;
      sum      <= sum_nxt;
      resp     <= resp_nxt;
      cnt      <= cnt_nxt;
      word     <= word_nxt;
      wait_cnt <= wait_nxt;
      is_wr    <= is_wr_nxt;
      halt     <= halt_nxt;
      crst     <= crst_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    addr_hi_nxt = addr_hi;
    data_hi_nxt = data_hi;
    word_lo_nxt = word_lo;
    sum_nxt     = sum;
    resp_nxt    = resp;
    cnt_nxt     = cnt;
    word_nxt    = word;
    wait_nxt    = wait_cnt;
    is_wr_nxt   = is_wr;
    halt_nxt    = halt;
    crst_nxt    = 1'b0;
    tx_load     = 1'b0;
    tx_byte     = '0;
    case (state)
      IDLE: if (rx_fire) begin
        case (rx_data)
          CMD_W: begin halt_nxt = 1'b1; is_wr_nxt = 1'b1; sum_nxt = '0; state_nxt = ADDR_H; end
          CMD_R: begin halt_nxt = 1'b1; is_wr_nxt = 1'b0; sum_nxt = '0; state_nxt = ADDR_H; end
          CMD_G: begin halt_nxt = 1'b0; crst_nxt = 1'b1; resp_nxt = ACK; state_nxt = RESP; end
          default: begin resp_nxt = UNK; state_nxt = RESP; end
        endcase
      end
      ADDR_H: if (rx_fire) begin
        addr_hi_nxt = rx_data; sum_nxt = sum_in; state_nxt = ADDR_L;
      end
      ADDR_L: if (rx_fire) begin
        addr_nxt = ADDR_W'({addr_hi, rx_data}); sum_nxt = sum_in; state_nxt = COUNT;
      end
      COUNT: if (rx_fire) begin
        cnt_nxt   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
        sum_nxt   = sum_in;
        state_nxt = is_wr ? DAT_H : RD_ISSUE;
      end
      DAT_H: if (rx_fire) begin
        data_hi_nxt = rx_data; sum_nxt = sum_in; state_nxt = DAT_L;
      end
      DAT_L: if (rx_fire) begin
        word_nxt = {data_hi, rx_data}; sum_nxt = sum_in; state_nxt = WRITE;
      end
      WRITE: begin
        addr_nxt  = addr + ADDR_W'(1);
        cnt_nxt   = cnt - 9'd1;
        state_nxt = (cnt == 9'd1) ? CHECK : DAT_H;
      end
      // The checksum byte is consumed here and its verdict loaded straight into tx.
      CHECK: if (rx_fire) begin
        tx_load   = 1'b1;
        tx_byte   = (sum_in == 8'd0) ? ACK : NAK;
        state_nxt = RESP;
      end
      RD_ISSUE: begin
        wait_nxt  = '0;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_nxt = SEND_H;
        else                       wait_nxt  = wait_cnt + WAIT_W'(1);
      end
      // Entry cycle of SEND_H is RD_LAT cycles after RD_ISSUE, so flash_q is valid.
      SEND_H: begin
        if (!tx_valid) begin
          tx_load     = 1'b1;
          tx_byte     = flash_q[15:8];
          word_lo_nxt = flash_q[7:0];
        end else if (tx_ready) begin
          state_nxt = SEND_L;
        end
      end
      SEND_L: begin
        if (!tx_valid) begin
          tx_load = 1'b1;
          tx_byte = word_lo;
        end else if (tx_ready) begin
          addr_nxt = addr + ADDR_W'(1);
          cnt_nxt  = cnt - 9'd1;
          if (cnt == 9'd1) begin
            resp_nxt  = ACK;
            state_nxt = RESP;
          end else begin
            state_nxt = RD_ISSUE;
          end
        end
      end
      RESP: begin
        if (!tx_valid) begin
          tx_load = 1'b1;
          tx_byte = resp;
        end else if (tx_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
